// File: rtl/press_event_arbiter_pkg.sv
// press_pkg: shared definitions for the press event arbiter.
//   state_t        : arbiter FSM state encoding (ST_IDLE, ST_OFFER, ST_GAP)
//   clog2()        : ceiling log2 for elaboration-time width math
//   ch_w(NUM_CH)   : channel index width, at least 1
//   gap_w(GAP)     : inter-event gap counter width, clog2(GAP+1), at least 1
package press_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int ch_w(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

    function automatic int gap_w(input int gap);
        return (clog2(gap + 1) < 1) ? 1 : clog2(gap + 1);
    endfunction

endpackage

// File: rtl/press_event_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   : per-channel request bits
//   ptr_i   : channel where the search starts (wraps past NUM_CH-1)
//   any_o   : at least one request is set
//   grant_o : first requesting channel at or after ptr_i
module rr_pick
    import press_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CW     = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CW-1:0]     ptr_i,
    output logic              any_o,
    output logic [CW-1:0]     grant_o
);

    logic [CW-1:0] idx;

    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CW'((int'(ptr_i) + k) % NUM_CH);
            if (!any_o && req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/press_event_arbiter.sv
// press_event_arbiter: latches per-channel short/long press pulses as pending
// requests and offers them one at a time, round-robin, on a valid/ready port,
// holding off GAP idle cycles after every accepted event.
//   clk, rst           : clock, synchronous active-high reset
//   ev_in, ev_long     : per-channel event pulse and its long/short tag
//   out_ready          : consumer accepts the offered event
//   out_valid, out_ch,
//   out_long           : registered offered event
//   ovf, ovf_clr       : sticky per-channel overflow flags and their clear
module press_event_arbiter
    import press_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int GAP    = 2,
    localparam int CW     = ch_w(NUM_CH),
    localparam int GW     = gap_w(GAP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ev_in,
    input  logic [NUM_CH-1:0] ev_long,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic              out_long,
    output logic [NUM_CH-1:0] ovf,
    input  logic              ovf_clr
);

    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pend_long_q, pend_long_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              out_valid_q, out_valid_d;
    logic [CW-1:0]     out_ch_q, out_ch_d;
    logic              out_long_q, out_long_d;

    logic              any;
    logic [CW-1:0]     g;
    logic              grant;
    logic              hs;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] ovf_set;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req_i   (pend_q),
        .ptr_i   (ptr_q),
        .any_o   (any),
        .grant_o (g)
    );

    assign grant    = (state_q == ST_IDLE) && any;
    assign hs       = out_valid_q && out_ready;
    assign grant_oh = grant ? (NUM_CH'(1) << g) : '0;

    // A pulse on the channel being granted re-arms it instead of overflowing.
    assign ovf_set     = ev_in & pend_q & ~grant_oh;
    assign pend_d      = (pend_q & ~grant_oh) | ev_in;
    assign pend_long_d = (pend_long_q & ~ev_in) | (ev_long & ev_in);
    assign ovf_d       = (ovf_clr ? '0 : ovf_q) | ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            pend_long_q <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_long_q <= pend_long_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_long_q  <= out_long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any) state_d = ST_OFFER;
            ST_OFFER: if (out_ready) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle early so they leave the block registered.
    always_comb begin
        out_valid_d = (state_d == ST_OFFER);
        out_ch_d    = grant ? g : out_ch_q;
        out_long_d  = grant ? pend_long_q[g] : out_long_q;
        ptr_d       = ptr_q;
        if (hs) ptr_d = (out_ch_q == CW'(NUM_CH - 1)) ? '0 : out_ch_q + 1'b1;
        gap_d = gap_q;
        if (state_q == ST_OFFER && hs)
            gap_d = GAP_LOAD;
        else if (state_q == ST_GAP && gap_q != '0)
            gap_d = gap_q - 1'b1;
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_long  = out_long_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/press_event_arbiter.md
# press_event_arbiter

Round-robin scheduler that shares one downstream event consumer between NUM_CH press-detector channels. Each channel's detector emits single-cycle event pulses tagged short or long. This block latches them as per-channel pending requests and offers them one at a time on a valid/ready port. After each accepted event it enforces a programmable inter-event gap. It sits between the bank of per-button pulse-width detectors and the command decoder.

## Interface
Parameters:
- NUM_CH, 4: number of requesting detector channels (2..16).
- GAP, 2: idle cycles enforced after each accepted event (0 allowed).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ev_in  in  NUM_CH  per-channel event pulse, one cycle per detected press.
- ev_long  in  NUM_CH  classification qualifying ev_in[i]: 1 = long press, 0 = short.
- out_ready  in  1  consumer accepts the offered event this cycle.
- out_valid  out  1  event offered.
- out_ch  out  clog2(NUM_CH)  channel index of offered event.
- out_long  out  1  classification of offered event.
- ovf  out  NUM_CH  sticky per-channel overflow flags.
- ovf_clr  in  1  clears all ovf bits.

## Operation
- Per channel i: pend[i] and pend_long[i] registers.
- ev_in[i] sets pend[i] and loads pend_long[i] <= ev_long[i].
- ev_in[i] while pend[i] is already set and not being granted this cycle:
  - ovf[i] is set.
  - pend_long[i] is overwritten; the latest event wins.
- Grant clears pend[i]. An ev_in[i] in the same cycle as its grant re-sets pend[i] with the new data and does not set ovf[i].
- ovf_clr clears all ovf bits. A new overflow in the same cycle wins; that bit stays set.
- Round-robin pointer ptr, range 0..NUM_CH-1, reset 0.
  - The search starts at ptr and wraps around.
  - After a handshake, ptr <= (out_ch + 1) mod NUM_CH.
- State machine:
  - IDLE: if any pend bit is set, grant channel g = first set bit at or after ptr. The grant loads out_ch <= g and out_long <= pend_long[g], clears pend[g], and moves to OFFER. If no pend bit is set, stay in IDLE.
  - OFFER: out_valid = 1 and out_ch/out_long are held stable. On out_valid && out_ready, update ptr and go to GAP if GAP > 0, else to IDLE.
  - GAP: the counter runs from GAP-1 down to 0, then the state returns to IDLE. out_valid = 0 throughout.
- Events arriving in OFFER or GAP only update pend/ovf. They never alter the offered data.
- All outputs are registered.

## Timing
- Reset values: out_valid 0, out_ch 0, out_long 0, ovf all 0, pend all 0, ptr 0, state IDLE, gap counter 0.
- Reset asserted mid-offer: out_valid is low after the next edge and any pending events are discarded.
- Latency: ev_in high in cycle 0, arbiter idle → pend set at edge 1 → out_valid high in cycle 2.
- Handshake:
  - The transfer occurs on the edge where out_valid && out_ready.
  - out_valid falls at that edge.
  - out_valid must not drop without a handshake, except on rst.
- Minimum spacing between consecutive out_valid rises is GAP + 2 cycles: handshake edge, GAP cycles, IDLE grant cycle.
- With GAP = 0: back-to-back offers separated by one low cycle (the IDLE grant cycle).
- out_ready held high with out_valid low has no effect.

## Structure
- Shared package press_pkg holds:
  - state encoding constants ST_IDLE, ST_OFFER, ST_GAP;
  - clog2 function;
  - widths derived from NUM_CH and GAP (gap counter width clog2(GAP+1), minimum 1).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: any, grant index.
  - Instantiated once.

## Test plan
- Reset then single event: ev_in=4'b0100, ev_long=4'b0100 in cycle 0, out_ready=1 → out_valid in cycle 2 with out_ch=2, out_long=1. Next out_valid ≥ GAP+2 cycles later only if another event arrives. ovf=0.
- Simultaneous requests: ev_in=4'b1111 in one cycle, out_ready=1, GAP=2 → grants in order 0,1,2,3; out_valid rises spaced 4 cycles apart.
- Fairness/wrap: ptr=3 after a channel-2 grant, ev_in=4'b1001 → order is 3 then 0.
- Backpressure and overflow:
  - Channel 1 is offered, out_ready=0 for 10 cycles.
  - Channel 1 pulses short, then long, during OFFER → offered event unchanged, ovf[1]=1.
  - After ready: the next event for channel 1 has out_long=1.
  - ovf_clr pulse → ovf=0.
- Grant/event collision: ev_in[0] pulses on the same cycle channel 0 is granted → pend[0] re-set, ovf[0] stays 0, second channel-0 event is delivered.
- Reset mid-operation: rst during OFFER with 3 pending channels → next cycle out_valid=0, pend=0, and no event is offered until new ev_in.
